uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: tx_data  input  8  byte to transmit; sampled only at frame acceptance.
REQ-005 SHALL have port: txEn  input  1  transmitter enable; a frame can be accepted only while high.
REQ-006 SHALL have port: txStart  input  1  start request; level-sensitive with re-arm rule (REQ-011).
REQ-007 SHALL have port: tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-008 SHALL have port: txBusy  output  1  high while a frame is in progress.
REQ-009 SHALL have port: txDone  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL accept a frame in any cycle where state=IDLE, armed=1, txEn=1 and txStart=1.
REQ-011 SHALL clear armed on acceptance, and set armed in any cycle where txStart=0; a held-high txStart SHALL NOT start a second frame.
REQ-012 SHALL latch tx_data into an 8-bit shift register on the acceptance edge; later tx_data changes SHALL NOT affect the frame.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, DONE: IDLE->START on acceptance; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bit periods; STOP->DONE after CLKS_PER_BIT cycles; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL drive tx=0 for exactly CLKS_PER_BIT cycles in START, beginning the cycle after acceptance.
REQ-015 SHALL drive data bits LSB first, each for exactly CLKS_PER_BIT cycles, using a 3-bit bit index that ends at 7 and does not wrap into a ninth bit.
REQ-016 SHALL drive tx=1 in STOP, DONE and IDLE.
REQ-017 SHALL use a baud counter of width ceil(log2(CLKS_PER_BIT)) that counts 0..CLKS_PER_BIT-1 and clears on each bit boundary and on acceptance.
REQ-018 SHALL assert txBusy from the cycle after acceptance through the last STOP cycle, registered, with no gaps between bits.
REQ-019 SHALL assert txDone for exactly one cycle in DONE, with txBusy=0 in that same cycle.
REQ-020 SHALL make frame length from acceptance to txDone exactly 10*CLKS_PER_BIT+1 cycles.
REQ-021 SHALL ignore txEn and txStart once a frame has started; deasserting txEn mid-frame SHALL NOT truncate it.
REQ-022 SHALL allow back-to-back frames: acceptance is possible in the first IDLE cycle after DONE if armed=1.
REQ-023 SHALL treat txStart=1 with txEn=0 as no request, without clearing armed.
REQ-024 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, on rst_n=0 and independent of clk, force state=IDLE, tx=1, txBusy=0, txDone=0, armed=1, and clear the baud counter, bit index and shift register.
REQ-026 SHALL abort a frame on reset mid-frame, returning tx high immediately with no txDone pulse.
REQ-027 SHALL, after rst_n deasserts synchronously to clk, accept a frame on the first rising edge satisfying REQ-010.

Verification (CLKS_PER_BIT=4)
REQ-028 Single frame: tx_data=0xA5, txEn=1, txStart pulsed for 1 cycle -> tx reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; txBusy high for 40 cycles; txDone pulses at cycle 41 after acceptance.
REQ-029 Held start: txStart held high for 100 cycles with tx_data=0x3C -> exactly one frame is sent, one txDone pulse occurs, and tx stays high after the frame.
REQ-030 Back-to-back: txStart drops the cycle after txDone and rises the next cycle with 0x00 then 0xFF -> the second start bit begins within 2 cycles of the first txDone, and both bytes are correct.
REQ-031 Data stability: tx_data changes from 0x81 to 0x7E in the cycle after acceptance -> serial bits reflect 0x81.
REQ-032 Enable gating: txEn=0, txStart=1 for 20 cycles -> tx=1 and txBusy=0 throughout; txEn rises -> frame accepted the same cycle.
REQ-033 Reset mid-frame: rst_n low during data bit 3 -> tx=1 and txBusy=0 asynchronously, no txDone pulse; a new request after release sends a full frame.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: LSB first, idle-high line, registered outputs.
// One frame per txStart assertion, gated by txEn; a held txStart does not retrigger.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       txEn,
  input  logic       txStart,
  output logic       tx,
  output logic       txBusy,
  output logic       txDone
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          armed, armed_d;
  logic          tx_d, busy_d, done_d;
  logic          accept;
  logic          baud_last;

  assign accept    = (state == IDLE) && armed && txEn && txStart;
  assign baud_last = (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      armed   <= 1'b1;
      tx      <= 1'b1;
      txBusy  <= 1'b0;
      txDone  <= 1'b0;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      armed   <= armed_d;
      tx      <= tx_d;
      txBusy  <= busy_d;
      txDone  <= done_d;
    end
  end

  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    armed_d   = armed;

    if (!txStart) begin
      armed_d = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          baud_d    = '0;
          bit_idx_d = '0;
          shreg_d   = tx_data;
          armed_d   = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          baud_d  = '0;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          // Index stops at 7 and the last bit is never shifted out early.
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          state_d = DONE;
          baud_d  = '0;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they are registered yet aligned with the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = shreg_d[0];
        busy_d = 1'b1;
      end
      STOP: begin
        busy_d = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        tx_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-position reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int LAST_POS = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       txEn;
  logic       txStart;
  logic       tx;
  logic       txBusy;
  logic       txDone;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .txEn    (txEn),
    .txStart (txStart),
    .tx      (tx),
    .txBusy  (txBusy),
    .txDone  (txDone)
  );

  always #5 clk = ~clk;

  // Reference: pos is the cycle index inside the current frame (-1 when idle).
  int         pos = -1;
  bit         armed_m = 1'b1;
  bit         acc_m;
  logic [7:0] byte_m = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos     = -1;
      armed_m = 1'b1;
    end else begin
      acc_m = (pos < 0) && armed_m && (txEn === 1'b1) && (txStart === 1'b1);
      if (pos >= 0) begin
        pos = (pos == LAST_POS) ? -1 : pos + 1;
      end else if (acc_m) begin
        pos    = 0;
        byte_m = tx_data;
      end
      if (acc_m) armed_m = 1'b0;
      else if (txStart === 1'b0) armed_m = 1'b1;
    end
  end

  function automatic logic [2:0] expect_out(int p, logic [7:0] b);
    if (p < 0) return 3'b100;
    if (p < CPB) return 3'b010;
    if (p < 9 * CPB) return {b[3'((p - CPB) / CPB)], 2'b10};
    if (p < LAST_POS) return 3'b110;
    return 3'b101;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    e = expect_out(pos, byte_m);
    check("model_tx", int'(tx), int'(e[2]));
    check("model_busy", int'(txBusy), int'(e[1]));
    check("model_done", int'(txDone), int'(e[0]));
  end

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (txDone !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, int'(txDone === 1'b1), 1);
  endtask

  // Call at the first start-bit cycle; samples each data bit mid-period.
  task automatic decode(output logic [7:0] b);
    b = '0;
    repeat (CPB + CPB / 2) @(negedge clk);
    b[0] = tx;
    for (int i = 1; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[3'(i)] = tx;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] exp_bits;
    logic [7:0] b;
    int busy_cnt, done_at, done_cnt;
    bit ok;

    rst_n   = 1'b0;
    tx_data = '0;
    txEn    = 1'b0;
    txStart = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(txBusy), 0);
    check("reset_done", int'(txDone), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame: 0,1,0,1,0,0,1,0,1,1 with bit 0 of exp_bits first on the line.
    exp_bits = 10'b11_0100_1010;
    tx_data = 8'hA5;
    txEn    = 1'b1;
    txStart = 1'b1;
    @(negedge clk);
    txStart  = 1'b0;
    busy_cnt = 0;
    done_at  = 0;
    for (int c = 1; c <= 41; c++) begin
      if (c <= 40) check("a5_bit", int'(tx), int'(exp_bits[4'((c - 1) / 4)]));
      if (txBusy) busy_cnt++;
      if (txDone && done_at == 0) done_at = c;
      @(negedge clk);
    end
    check("a5_busy_cycles", busy_cnt, 40);
    check("a5_done_cycle", done_at, 41);

    // Held start: one frame only.
    tx_data  = 8'h3C;
    txStart  = 1'b1;
    done_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (txDone) done_cnt++;
    end
    check("held_done_count", done_cnt, 1);
    check("held_idle_tx", int'(tx), 1);
    check("held_idle_busy", int'(txBusy), 0);
    txStart = 1'b0;
    @(negedge clk);

    // Back-to-back 0x00 then 0xFF.
    tx_data = 8'h00;
    txStart = 1'b1;
    wait_done(60, "b2b_first");
    txStart = 1'b0;
    tx_data = 8'hFF;
    @(negedge clk);
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    check("b2b_start_within_2", int'(tx), 0);
    decode(b);
    check("b2b_second_byte", int'(b), 8'hFF);
    wait_done(60, "b2b_second");
    @(negedge clk);

    // Data stability: change tx_data right after acceptance.
    tx_data = 8'h81;
    txStart = 1'b1;
    @(negedge clk);
    tx_data = 8'h7E;
    txStart = 1'b0;
    decode(b);
    check("stable_byte", int'(b), 8'h81);
    wait_done(60, "stable");
    @(negedge clk);

    // Enable gating.
    txEn    = 1'b0;
    txStart = 1'b1;
    ok      = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || txBusy !== 1'b0) ok = 1'b0;
    end
    check("gated_idle", int'(ok), 1);
    txEn = 1'b1;
    @(negedge clk);
    check("gated_accept_busy", int'(txBusy), 1);
    check("gated_accept_tx", int'(tx), 0);
    txStart = 1'b0;
    wait_done(60, "gated");
    @(negedge clk);

    // Reset during data bit 3.
    tx_data = 8'($urandom);
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", int'(tx), 1);
    check("rst_async_busy", int'(txBusy), 0);
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (txDone !== 1'b0) ok = 1'b0;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (txDone !== 1'b0) ok = 1'b0;
    end
    check("rst_no_done", int'(ok), 1);
    tx_data = 8'($urandom);
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    wait_done(60, "post_reset");
    @(negedge clk);

    // Randomized traffic, including mid-frame enable drops and held starts.
    for (int i = 0; i < 3000; i++) begin
      txEn    = ($urandom_range(0, 7) != 0);
      txStart = ($urandom_range(0, 2) == 0);
      tx_data = 8'($urandom);
      @(negedge clk);
    end
    txStart = 1'b0;
    repeat (50) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
